// File: rtl/alu_cmd_sequencer.sv
// Command front end for the combinational ALU: decode, operand fetch, result capture, write-back, response.
// Optional ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_hi_nz result flags.
module alu_cmd_sequencer #(
    parameter int DATA_IN_WIDTH  = 32,
    parameter int OP_CODE_WIDTH  = 4,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int NUM_REGS       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_data,
    output logic [OP_CODE_WIDTH-1:0]  alu_op_code,
    output logic [DATA_IN_WIDTH-1:0]  alu_scalar_a,
    output logic [DATA_IN_WIDTH-1:0]  alu_scalar_b,
    input  logic [DATA_OUT_WIDTH-1:0] alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_OUT_WIDTH-1:0] rsp_data,
    output logic [3:0]                rsp_rd,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                      rsp_zero,
    output logic                      rsp_hi_nz,
`endif
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [DATA_IN_WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]               rd_q;

    logic [3:0]  f_op, f_rd, f_rs1, f_rs2;
    logic        f_imm_sel;
    logic [14:0] f_imm;
    logic        accept;

    assign f_op      = cmd_data[31:28];
    assign f_rd      = cmd_data[27:24];
    assign f_rs1     = cmd_data[23:20];
    assign f_rs2     = cmd_data[19:16];
    assign f_imm_sel = cmd_data[15];
    assign f_imm     = cmd_data[14:0];
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_q         <= '0;
            alu_op_code  <= '0;
            alu_scalar_a <= '0;
            alu_scalar_b <= '0;
            rsp_data     <= '0;
            rsp_rd       <= '0;
        end else begin
            if (accept) begin
                rd_q         <= f_rd;
                alu_op_code  <= OP_CODE_WIDTH'(f_op);
                alu_scalar_a <= (f_rs1 == 4'd0) ? '0 : regs[f_rs1];
                if (f_imm_sel) begin
                    alu_scalar_b <= DATA_IN_WIDTH'(f_imm);
                end else begin
                    alu_scalar_b <= (f_rs2 == 4'd0) ? '0 : regs[f_rs2];
                end
            end
            // Write-back lands before RESP, so the next accepted command always sees it.
            if (state == EXEC) begin
                rsp_data <= alu_result;
                rsp_rd   <= rd_q;
                if (rd_q != 4'd0) begin
                    regs[rd_q] <= alu_result[DATA_IN_WIDTH-1:0];
                end
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_zero  <= 1'b0;
            rsp_hi_nz <= 1'b0;
        end else if (state == EXEC) begin
            rsp_zero  <= (alu_result == '0);
            rsp_hi_nz <= |alu_result[DATA_OUT_WIDTH-1:DATA_IN_WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU stub and register-file model.
// Define ALU_SEQ_FLAGS_EN to also check the optional result flags.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [3:0]  alu_op_code;
    logic [31:0] alu_scalar_a;
    logic [31:0] alu_scalar_b;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_rd;
    logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_hi_nz;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] model_regs [16];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_IN_WIDTH (32),
        .OP_CODE_WIDTH (4),
        .DATA_OUT_WIDTH(64),
        .NUM_REGS      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .alu_op_code (alu_op_code),
        .alu_scalar_a(alu_scalar_a),
        .alu_scalar_b(alu_scalar_b),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_rd      (rsp_rd),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_zero    (rsp_zero),
        .rsp_hi_nz   (rsp_hi_nz),
`endif
        .busy        (busy)
    );

    // Stand-in for the external combinational ALU.
    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return {32'b0, a} + {32'b0, b};
            4'd1:    return {32'b0, a - b};
            4'd2:    return {32'b0, a} * {32'b0, b};
            4'd3:    return (b == 0) ? 64'd0 : {32'b0, a / b};
            4'd4:    return {32'b0, a & b};
            4'd5:    return {32'b0, a | b};
            4'd6:    return {32'b0, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    assign alu_result = alu_f(alu_op_code, alu_scalar_a, alu_scalar_b);

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic isel, input logic [14:0] imm,
                           input int stall, input string name);
        logic [31:0] a, b;
        logic [63:0] exp;
        int waited;
        a   = model_regs[rs1];
        b   = isel ? {17'b0, imm} : model_regs[rs2];
        exp = alu_f(op, a, b);
        @(negedge clk);
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready_timeout: cmd_ready=%b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_data  = {op, rd, rs1, rs2, isel, imm};
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Garbage on the command channel while busy must be ignored.
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data  = $urandom;
        tests++;
        if (alu_op_code !== op || alu_scalar_a !== a || alu_scalar_b !== b) begin
            fails++;
            $display("FAIL %s_issue: op=%h a=%h b=%h want op=%h a=%h b=%h",
                     name, alu_op_code, alu_scalar_a, alu_scalar_b, op, a, b);
        end
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_exec_ctl: busy=%b cmd_ready=%b rsp_valid=%b want 1 0 0",
                     name, busy, cmd_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_rd !== rd) begin
            fails++;
            $display("FAIL %s_rsp: valid=%b data=%h rd=%h want 1 %h %h", name, rsp_valid, rsp_data, rsp_rd, exp, rd);
        end
`ifdef ALU_SEQ_FLAGS_EN
        tests++;
        if (rsp_zero !== (exp == 0) || rsp_hi_nz !== (exp[63:32] != 0)) begin
            fails++;
            $display("FAIL %s_flags: zero=%b hi_nz=%b want %b %b", name, rsp_zero, rsp_hi_nz,
                     (exp == 0), (exp[63:32] != 0));
        end
`endif
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_rd !== rd || cmd_ready !== 1'b0 || alu_scalar_a !== a) begin
                fails++;
                $display("FAIL %s_stall%0d: valid=%b data=%h rd=%h cmd_ready=%b a=%h want 1 %h %h 0 %h",
                         name, i, rsp_valid, rsp_data, rsp_rd, cmd_ready, alu_scalar_a, exp, rd, a);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || alu_scalar_a !== a || alu_scalar_b !== b) begin
            fails++;
            $display("FAIL %s_done: rsp_valid=%b cmd_ready=%b busy=%b a=%h b=%h want 0 1 0 %h %h",
                     name, rsp_valid, cmd_ready, busy, alu_scalar_a, alu_scalar_b, a, b);
        end
        if (rd != 0) model_regs[rd] = exp[31:0];
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 64'd0 ||
            rsp_rd !== 4'd0 || alu_op_code !== 4'd0 || alu_scalar_a !== 32'd0 || alu_scalar_b !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b busy=%b rsp_valid=%b data=%h rd=%h op=%h a=%h b=%h want 1 0 0 0 0 0 0 0",
                     cmd_ready, busy, rsp_valid, rsp_data, rsp_rd, alu_op_code, alu_scalar_a, alu_scalar_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_spec_vectors;
        run_cmd(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 15'd5, 0, "imm_load_r1");
        run_cmd(4'd0, 4'd7, 4'd1, 4'd0, 1'b1, 15'd0, 0, "read_r1");
        run_cmd(4'd2, 4'd2, 4'd1, 4'd0, 1'b1, 15'h7FFF, 0, "mul_imm");
        run_cmd(4'd0, 4'd8, 4'd2, 4'd0, 1'b1, 15'd0, 0, "read_r2");
        run_cmd(4'd3, 4'd3, 4'd1, 4'd0, 1'b0, 15'd0, 0, "div_by_zero");
        run_cmd(4'd0, 4'd9, 4'd3, 4'd0, 1'b1, 15'd0, 0, "read_r3");
        run_cmd(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 15'd9, 0, "write_r0");
        run_cmd(4'd0, 4'd10, 4'd0, 4'd0, 1'b1, 15'd0, 0, "read_r0");
        run_cmd(4'd15, 4'd11, 4'd2, 4'd1, 1'b0, 15'd0, 0, "wide_truncate");
        run_cmd(4'd0, 4'd12, 4'd11, 4'd0, 1'b1, 15'd0, 0, "read_r11");
    endtask

    task automatic test_backpressure;
        run_cmd(4'd1, 4'd4, 4'd2, 4'd1, 1'b0, 15'd0, 10, "stall10");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 15'($urandom),
                    $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_reset_mid_exec;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = {4'd0, 4'd5, 4'd2, 4'd0, 1'b1, 15'd123};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_accept: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 64'd0 || rsp_rd !== 4'd0 ||
            alu_scalar_a !== 32'd0 || alu_scalar_b !== 32'd0) begin
            fails++;
            $display("FAIL midreset_state: rsp_valid=%b ready=%b data=%h rd=%h a=%h b=%h want 0 1 0 0 0 0",
                     rsp_valid, cmd_ready, rsp_data, rsp_rd, alu_scalar_a, alu_scalar_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_no_rsp%0d: rsp_valid=%b want 0", i, rsp_valid);
            end
        end
        run_cmd(4'd0, 4'd6, 4'd5, 4'd0, 1'b1, 15'd0, 0, "midreset_read_r5");
        run_cmd(4'd0, 4'd6, 4'd2, 4'd0, 1'b1, 15'd0, 0, "midreset_read_r2");
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
